// File: rtl/clock_divider_ctrl.sv
// Run-time clock divider: tick enable plus 50%-duty div_clk, reloadable at period boundaries.
// Optional tick_cnt output when CLKDIV_TICKCNT_EN is defined.
module clock_divider_ctrl #(
  parameter int          CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 4999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             div_clk,
`ifdef CLKDIV_TICKCNT_EN
  output logic [15:0]      tick_cnt,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] act_q;
  logic [CNT_W-1:0] shd_q;
  logic             tick_q;
  logic             dclk_q;
  logic             busy_q;
  logic             acc_d;
  logic             term_d;
`ifdef CLKDIV_TICKCNT_EN
  logic [15:0]      tcnt_q;
`endif

  assign cfg_ready = (state_q != PEND);
  assign acc_d     = cfg_valid && cfg_ready;
  assign term_d    = (cnt_q == act_q);

  assign tick    = tick_q;
  assign div_clk = dclk_q;
  assign busy    = busy_q;
`ifdef CLKDIV_TICKCNT_EN
  assign tick_cnt = tcnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= DEF;
      shd_q   <= DEF;
      tick_q  <= 1'b0;
      dclk_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CLKDIV_TICKCNT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          dclk_q <= 1'b0;
`ifdef CLKDIV_TICKCNT_EN
          tcnt_q <= '0;
`endif
          if (acc_d) act_q <= cfg_div;
          if (run_en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN, PEND: begin
          if (!run_en) begin
            // A stop must not lose a value that was already handed over
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            dclk_q  <= 1'b0;
`ifdef CLKDIV_TICKCNT_EN
            tcnt_q  <= '0;
`endif
            if (state_q == PEND) act_q <= shd_q;
            else if (acc_d)      act_q <= cfg_div;
          end else begin
            if (term_d) begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
              dclk_q <= ~dclk_q;
`ifdef CLKDIV_TICKCNT_EN
              tcnt_q <= tcnt_q + 16'd1;
`endif
              if (state_q == PEND) begin
                act_q   <= shd_q;
                state_q <= RUN;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (acc_d) begin
              shd_q   <= cfg_div;
              state_q <= PEND;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench for clock_divider_ctrl: period-arithmetic model checked every cycle plus directed literals.
// Define CLKDIV_TICKCNT_EN to also exercise the tick_cnt output and its wrap.
module tb_clock_divider_ctrl;

  localparam int DEF = 4999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic        tick;
  logic        div_clk;
  logic        busy;
`ifdef CLKDIV_TICKCNT_EN
  logic [15:0] tick_cnt;
`endif

  clock_divider_ctrl #(.CNT_W(16), .DEFAULT_DIV(DEF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_en    (run_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .div_clk   (div_clk),
`ifdef CLKDIV_TICKCNT_EN
    .tick_cnt  (tick_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: elapsed edges since the period started; tick when a full period has elapsed
  bit          m_run  = 0;
  bit          m_pend = 0;
  bit          m_tick = 0;
  bit          m_dclk = 0;
  bit          m_acc;
  int          m_el   = 0;
  logic [15:0] m_div  = 16'(DEF);
  logic [15:0] m_shd  = 16'(DEF);
  logic [15:0] m_tc   = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_tick = 0; m_dclk = 0; m_el = 0;
      m_div = 16'(DEF); m_shd = 16'(DEF); m_tc = 16'd0;
    end else begin
      m_acc  = cfg_valid && !m_pend;
      m_tick = 0;
      if (!m_run) begin
        if (m_acc) m_div = cfg_div;
        if (run_en) begin
          m_run = 1;
          m_el  = 0;
        end
      end else if (!run_en) begin
        if (m_pend)     m_div = m_shd;
        else if (m_acc) m_div = cfg_div;
        m_run = 0;
        m_pend = 0;
      end else begin
        m_el++;
        if (m_el == int'(m_div) + 1) begin
          m_tick = 1;
          m_el = 0;
          m_dclk = !m_dclk;
          m_tc++;
          if (m_pend) begin
            m_div = m_shd;
            m_pend = 0;
          end
        end
        if (m_acc) begin
          m_shd = cfg_div;
          m_pend = 1;
        end
      end
      if (!m_run) begin
        m_dclk = 0;
        m_tc = 16'd0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_tick", 32'(tick), 32'(m_tick));
    chk("m_div_clk", 32'(div_clk), 32'(m_dclk));
    chk("m_busy", 32'(busy), 32'(m_run));
    chk("m_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
`ifdef CLKDIV_TICKCNT_EN
    chk("m_tick_cnt", 32'(tick_cnt), 32'(m_tc));
`endif
  end

  task automatic wait_tick(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (tick) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("tick_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_cfg(input logic [15:0] v);
    cfg_valid = 1'b1;
    cfg_div = v;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #(2000000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int e0, t, t2, ta;

  initial begin
    rst_n = 1'b0; run_en = 1'b0; cfg_valid = 1'b0; cfg_div = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_div_clk", 32'(div_clk), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Default divide
    run_en = 1'b1; e0 = cyc + 1;
    wait_tick(6000, t);
    chk("t1_first", 32'(t - e0), 5000);
    chk("t1_dclk_hi", 32'(div_clk), 1);
    @(negedge clk);
    chk("t1_width", 32'(tick), 0);
    wait_tick(6000, t2);
    chk("t1_period", 32'(t2 - t), 5000);
    chk("t1_dclk_lo", 32'(div_clk), 0);
    run_en = 1'b0;
    @(negedge clk);
    chk("t1_stop_busy", 32'(busy), 0);

    // Load 3 in idle
    send_cfg(16'd3);
    run_en = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    chk("t2_busy", 32'(busy), 1);
    wait_tick(20, t);
    chk("t2_first", 32'(t - e0), 4);
    wait_tick(20, t2);
    chk("t2_period", 32'(t2 - t), 4);

    // Reload to 7 two cycles after a tick
    repeat (2) @(negedge clk);
    send_cfg(16'd7);
    chk("t3_ready_low", 32'(cfg_ready), 0);
    wait_tick(20, t);
    chk("t3_cur_period", 32'(t - t2), 4);
    wait_tick(20, t2);
    chk("t3_new_period", 32'(t2 - t), 8);
    chk("t3_ready_back", 32'(cfg_ready), 1);
    send_cfg(16'd3);
    wait_tick(20, t);
    chk("t3_period_b", 32'(t - t2), 8);
    wait_tick(20, t2);
    chk("t4_base", 32'(t2 - t), 4);

    // Accept on the terminal-count edge; second cfg during PEND ignored
    repeat (3) @(negedge clk);
    cfg_valid = 1'b1; cfg_div = 16'd1;
    @(negedge clk);
    ta = cyc;
    chk("t4_tc_edge", 32'(tick), 1);
    chk("t4_ready_pend", 32'(cfg_ready), 0);
    cfg_div = 16'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_tick(20, t);
    chk("t4_full", 32'(t - ta), 4);
    wait_tick(20, t2);
    chk("t4_new_a", 32'(t2 - t), 2);
    wait_tick(20, t);
    chk("t4_new_b", 32'(t - t2), 2);

    // Stop while pending shadow=9
    send_cfg(16'd9);
    run_en = 1'b0;
    @(negedge clk);
    chk("t5_stop_dclk", 32'(div_clk), 0);
    chk("t5_stop_tick", 32'(tick), 0);
    chk("t5_stop_busy", 32'(busy), 0);
    run_en = 1'b1; e0 = cyc + 1;
    wait_tick(40, t);
    chk("t5_first", 32'(t - e0), 10);
    wait_tick(40, t2);
    chk("t5_period", 32'(t2 - t), 10);
    wait_tick(40, t);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arst_tick", 32'(tick), 0);
    chk("t5_arst_dclk", 32'(div_clk), 0);
    chk("t5_arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1; e0 = cyc + 1;
    wait_tick(6000, t);
    chk("t5_reset_div", 32'(t - e0), 5000);

    // Divide by zero: tick held high
    run_en = 1'b0;
    @(negedge clk);
    send_cfg(16'd0);
    run_en = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    chk("t6_e0_tick", 32'(tick), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_tick", 32'(tick), 1);
      chk("t6_dclk", 32'(div_clk), 32'((i % 2) == 0));
    end
`ifdef CLKDIV_TICKCNT_EN
    while (cyc < e0 + 65535) @(negedge clk);
    chk("t6_tc_max", 32'(tick_cnt), 65535);
    @(negedge clk);
    chk("t6_tc_wrap", 32'(tick_cnt), 0);
    run_en = 1'b0;
    @(negedge clk);
    chk("t6_tc_clear", 32'(tick_cnt), 0);
`endif
    run_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
